// File: rtl/hazard_ctrl_if.sv
// Hazard controller interface: pipeline-side hazard inputs and the
// stall/flush/error outputs, bundled so the pipeline and the controller
// connect through a single port. The pipeline uses the master modport,
// and the hazard controller uses the slave modport.
interface hazard_ctrl_if;
    logic [4:0]  rs1_d;
    logic [4:0]  rs2_d;
    logic        use_rs1;
    logic        use_rs2;
    logic [4:0]  rd_e;
    logic [4:0]  rd_m;
    logic        regwrite_e;
    logic        regwrite_m;
    logic        memread_e;
    logic        branch_taken_e;
    logic        dmem_ready;

    logic        stall_f;
    logic        stall_d;
    logic        stall_e;
    logic        stall_m;
    logic        flush_d;
    logic        flush_e;
    logic        flush_w;
    logic        mem_err;
    logic [15:0] stall_cnt;

    modport master (
        output rs1_d, rs2_d, use_rs1, use_rs2, rd_e, rd_m,
               regwrite_e, regwrite_m, memread_e, branch_taken_e, dmem_ready,
        input  stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_w, mem_err, stall_cnt
    );

    modport slave (
        input  rs1_d, rs2_d, use_rs1, use_rs2, rd_e, rd_m,
               regwrite_e, regwrite_m, memread_e, branch_taken_e, dmem_ready,
        output stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_w, mem_err, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage in-order core.
// This controller resolves RAW hazards, taken branches, and data-memory wait states.
// It also detects a sticky memory timeout and counts cycles in which fetch is stalled.
// Outputs are combinational from the registered state and the current inputs.
// Configuration macro FORWARDING_EN:
//   defined   -> only load-use hazards stall, because the datapath forwards ALU results.
//   undefined -> any in-flight writer in Execute or Memory that matches a used source causes a stall.
module hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERROR    = 2'b10
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = TIMEOUT[7:0];

    state_t      state_q, state_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        pend_q, pend_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic hold_f, hold_d, hold_e, hold_m;
    logic bub_d, bub_e, bub_w;
    logic err;

    logic hit_e;
    logic load_use;
    logic raw_hazard;

    assign hit_e = (hz.use_rs1 && (hz.rs1_d == hz.rd_e)) ||
                   (hz.use_rs2 && (hz.rs2_d == hz.rd_e));

    assign load_use = hz.memread_e && hz.regwrite_e && (hz.rd_e != 5'd0) && hit_e;

`ifdef FORWARDING_EN
    assign raw_hazard = load_use;
`else
    logic hit_m;

    assign hit_m = (hz.use_rs1 && (hz.rs1_d == hz.rd_m)) ||
                   (hz.use_rs2 && (hz.rs2_d == hz.rd_m));

    assign raw_hazard = load_use ||
                        (hz.regwrite_e && (hz.rd_e != 5'd0) && hit_e) ||
                        (hz.regwrite_m && (hz.rd_m != 5'd0) && hit_m);
`endif

    // Next-state, timeout/pending bookkeeping and stall/flush decode
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        pend_d  = pend_q;
        hold_f  = 1'b0;
        hold_d  = 1'b0;
        hold_e  = 1'b0;
        hold_m  = 1'b0;
        bub_d   = 1'b0;
        bub_e   = 1'b0;
        bub_w   = 1'b0;
        err     = 1'b0;

        case (state_q)
            RUN: begin
                tmo_d  = 8'd0;
                pend_d = 1'b0;
                if (!hz.dmem_ready) begin
                    hold_f  = 1'b1;
                    hold_d  = 1'b1;
                    hold_e  = 1'b1;
                    hold_m  = 1'b1;
                    bub_w   = 1'b1;
                    tmo_d   = 8'd1;
                    pend_d  = hz.branch_taken_e;
                    state_d = MEM_WAIT;
                end else if (hz.branch_taken_e) begin
                    bub_d = 1'b1;
                    bub_e = 1'b1;
                end else if (raw_hazard) begin
                    hold_f = 1'b1;
                    hold_d = 1'b1;
                    bub_e  = 1'b1;
                end
            end

            MEM_WAIT: begin
                if (!hz.dmem_ready) begin
                    hold_f = 1'b1;
                    hold_d = 1'b1;
                    hold_e = 1'b1;
                    hold_m = 1'b1;
                    bub_w  = 1'b1;
                    pend_d = pend_q || hz.branch_taken_e;
                    tmo_d  = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
                    if (tmo_q == TIMEOUT_LIM) begin
                        state_d = ERROR;
                    end
                end else begin
                    // A branch resolved during the wait is flushed now, once memory completes.
                    // Decode hazards are re-examined next cycle in RUN.
                    if (pend_q || hz.branch_taken_e) begin
                        bub_d = 1'b1;
                        bub_e = 1'b1;
                    end
                    pend_d  = 1'b0;
                    tmo_d   = 8'd0;
                    state_d = RUN;
                end
            end

            ERROR: begin
                hold_f = 1'b1;
                hold_d = 1'b1;
                hold_e = 1'b1;
                hold_m = 1'b1;
                bub_w  = 1'b1;
                err    = 1'b1;
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Saturating count of fetch-stall cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hold_f && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State and counter registers; reset abandons any pending flush or wait
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            tmo_q       <= 8'd0;
            pend_q      <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            pend_q      <= pend_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // While reset is held, the pipeline sees no stalls or flushes.
    assign hz.stall_f   = hold_f & ~rst;
    assign hz.stall_d   = hold_d & ~rst;
    assign hz.stall_e   = hold_e & ~rst;
    assign hz.stall_m   = hold_m & ~rst;
    assign hz.flush_d   = bub_d  & ~rst;
    assign hz.flush_e   = bub_e  & ~rst;
    assign hz.flush_w   = bub_w  & ~rst;
    assign hz.mem_err   = err    & ~rst;
    assign hz.stall_cnt = stall_cnt_q;
endmodule
